// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Pipelined instruction fetch with credit-limited request issue and
//            an N-deep PC/instruction queue handed to decode via valid/ready.
// Revision : 1.0
// ============================================================================
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          QUEUE_DEPTH  = 4,
    parameter int          MAX_OUTSTAND = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    input  logic        inst_ready
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTAND + 1);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] kill_q, kill_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      inst_mem_q [QUEUE_DEPTH];
    logic [31:0]      inst_mem_d [QUEUE_DEPTH];
    logic [31:0]      pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]      pc_mem_d   [QUEUE_DEPTH];

    logic [SUM_W-1:0] credit_used;
    logic             grant;
    logic             resp_ok;
    logic             drop;
    logic             enq;
    logic             deq;

    // Slots already promised to in-flight requests count against queue space,
    // so every response is guaranteed a free entry.
    assign credit_used = SUM_W'(count_q) + SUM_W'(outstanding_q);
    assign imem_req    = !rst && !redirect
                         && (credit_used < SUM_W'(QUEUE_DEPTH))
                         && (outstanding_q < OUT_W'(MAX_OUTSTAND));
    assign imem_addr   = fetch_pc_q;

    assign grant   = imem_req && imem_gnt;
    assign resp_ok = imem_rvalid && (outstanding_q != '0);
    assign drop    = resp_ok && (kill_q != '0);
    assign enq     = resp_ok && !drop && !redirect;

    assign inst_valid = (count_q != '0);
    assign inst_out   = inst_mem_q[rd_ptr_q];
    assign pc_out     = pc_mem_q[rd_ptr_q];
    assign deq        = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        kill_d        = kill_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        inst_mem_d    = inst_mem_q;
        pc_mem_d      = pc_mem_q;
        outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(resp_ok);

        if (redirect) begin
            // Every request still in flight after this cycle belongs to the old path.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            kill_d     = outstanding_d;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (drop) begin
                kill_d = kill_q - OUT_W'(1);
            end
            if (enq) begin
                inst_mem_d[wr_ptr_q] = imem_rdata;
                pc_mem_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                resp_pc_d            = resp_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            kill_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inst_mem_q    <= inst_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Self-checking bench for fetch_queue_unit with an in-order memory
//            model and a program-order stream reference.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH  = 4;
    localparam int          MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ready;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH),
        .MAX_OUTSTAND(MAXO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .inst_ready (inst_ready)
    );

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl [9];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          ngrant = 0;
    int          nacc = 0;
    int          pend_due [$];
    logic [31:0] pend_addr [$];
    logic [31:0] acc_q [$];
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    bit          redir_prev = 1'b0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called at a falling edge; ends at the next falling edge.
    task automatic step(input bit g, input bit rdy, input bit redir,
                        input logic [31:0] tgt, input bit spur);
        bit resp_now;
        int due;
        resp_now = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend_addr[0]);
            pend_due.delete(0);
            pend_addr.delete(0);
            resp_now = 1'b1;
        end else if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt    = g;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = tgt;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
        s_pc  = pc_out;   s_inst = inst_out;
        if (redir_prev) chk("flush_valid", inst_valid, 0);
        if (redir) chk("no_req_on_redirect", imem_req, 0);
        if (imem_req && g) begin
            chk("grant_addr", imem_addr, exp_fetch);
            chk("inflight_limit", ((pend_due.size() + int'(resp_now)) < MAXO), 1);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_due.push_back(due);
            pend_addr.push_back(imem_addr);
            exp_fetch = exp_fetch + 32'd4;
            ngrant++;
        end
        if (inst_valid && rdy) begin
            chk("deq_pc", pc_out, exp_pc);
            chk("deq_inst", inst_out, word_of(exp_pc));
            acc_q.push_back(pc_out);
            exp_pc = exp_pc + 32'd4;
            nacc++;
        end
        if (redir) begin
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end
        redir_prev = redir;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Outputs must clear the moment reset rises; responses still owed by the
    // memory are forgotten.
    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", pc_out, 0);
        @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        pend_due.delete(); pend_addr.delete(); acc_q.delete();
        last_due = cyc; exp_fetch = RST_PC; exp_pc = RST_PC; redir_prev = 1'b0;
    endtask

    initial begin
        int          g0, a0;
        bit          found;
        logic [31:0] addr0;
        redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; inst_ready = 1'b0; exp_fetch = RST_PC; exp_pc = RST_PC;

        //          gnt   rdy   req   addr     valid pc
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        // Streaming at latency 1, cycle by cycle
        lat = 1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].gnt, tbl[i].rdy, 1'b0, 32'h0, 1'b0);
            chk("t1_req", s_req, tbl[i].e_req);
            chk("t1_addr", s_addr, tbl[i].e_addr);
            chk("t1_valid", s_valid, tbl[i].e_valid);
            chk("t1_pc", s_pc, tbl[i].e_pc);
            chk("t1_inst", s_inst, tbl[i].e_valid ? word_of(tbl[i].e_pc) : 32'h0);
        end

        // Decode stalled: queue fills to DEPTH, then drains in order
        do_reset();
        g0 = ngrant;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_grants_when_full", ngrant - g0, DEPTH);
        chk("t2_req_low_full", s_req, 0);
        chk("t2_valid_held", s_valid, 1);
        chk("t2_head_pc", s_pc, RST_PC);
        a0 = nacc; g0 = ngrant;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("t2_drain_valid", s_valid, 1);
        end
        chk("t2_drained", nacc - a0, 4);
        chk("t2_refetch", (ngrant > g0), 1);

        // Grant withheld: address holds; then reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        addr0 = s_addr;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("t5_req_held", s_req, 1);
            chk("t5_addr_stable", s_addr, addr0);
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_restart_any", (acc_q.size() > 0), 1);
        if (acc_q.size() > 0) chk("t5_restart_pc", acc_q[0], RST_PC);

        // Response with nothing outstanding must be ignored
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("spur_no_valid", s_valid, 0);
        end

        // Latency 3: redirect with two requests in flight
        do_reset();
        lat = 3;
        step(1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
        for (int k = 0; k < 12 && !(pend_addr.size() == 2 && pend_addr[0] == 32'h10); k++)
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_two_inflight", (pend_addr.size() == 2 && pend_addr[0] == 32'h10
                                && pend_addr[1] == 32'h14), 1);
        step(1'b1, 1'b1, 1'b1, 32'h103, 1'b0);
        acc_q.delete();
        for (int k = 0; k < 20 && acc_q.size() == 0; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_got_inst", (acc_q.size() > 0), 1);
        if (acc_q.size() > 0) chk("t3_first_pc", acc_q[0], 32'h100);

        // Redirect coinciding with the last outstanding response
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (pend_due.size() == 1 && pend_due[0] == cyc) begin
                step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
                found = 1'b1;
            end else if (pend_due.size() == 0) begin
                step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            end else begin
                step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            end
        end
        chk("t4_scenario_hit", found, 1);
        acc_q.delete();
        for (int k = 0; k < 20 && acc_q.size() == 0; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_got_inst", (acc_q.size() > 0), 1);
        if (acc_q.size() > 0) chk("t4_first_pc", acc_q[0], 32'h200);

        // Address wrap at the top of memory
        lat = 1;
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        acc_q.delete();
        for (int k = 0; k < 20 && acc_q.size() < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_got_three", (acc_q.size() >= 3), 1);
        if (acc_q.size() >= 3) begin
            chk("t6_pc0", acc_q[0], 32'hFFFF_FFF8);
            chk("t6_pc1", acc_q[1], 32'hFFFF_FFFC);
            chk("t6_pc2", acc_q[2], 32'h0000_0000);
        end

        // Random traffic against the stream reference
        do_reset();
        a0 = nacc;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) lat = int'($urandom_range(1, 4));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0, $urandom, 1'b0);
        end
        chk("rand_progress", (nacc - a0 > 100), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
